// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode enum and default parameters.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned DEF_DATASIZE = 8;
  localparam int unsigned DEF_ADDRSIZE = 4;
  localparam int unsigned DEF_AF_LEVEL = 14;
  localparam int unsigned DEF_AE_LEVEL = 2;
  localparam int unsigned DEF_FWFT     = 0;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, contents never reset.
module sync_fifo_mem #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, sticky error flags and
// selectable standard / first-word-fall-through read port.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DEF_DATASIZE,
  parameter int unsigned ADDRSIZE = DEF_ADDRSIZE,
  parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
  parameter int unsigned FWFT     = DEF_FWFT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  input  logic                clr_err,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned AW    = ADDRSIZE;
  localparam int unsigned CW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_ok, rd_ok;
  logic [DATASIZE-1:0] mem_rdata;

  // Acceptance uses the registered flags, so a simultaneous pop never frees a slot for a full write.
  always_comb begin
    wr_ok   = winc && !full_q;
    rd_ok   = rinc && !empty_q;
    wptr_d  = wptr_q + CW'(wr_ok);
    rptr_d  = rptr_q + CW'(rd_ok);
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
    ovf_d   = (ovf_q && !clr_err) || (winc && full_q);
    unf_d   = (unf_q && !clr_err) || (rinc && empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DATASIZE(DATASIZE),
    .ADDRSIZE(ADDRSIZE)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_ok),
    .waddr_i(wptr_q[AW-1:0]),
    .wdata_i(wdata),
    .raddr_i(rptr_q[AW-1:0]),
    .rdata_o(mem_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head word is presented directly; zero while nothing is stored so reset reads as 0.
    assign rdata  = empty_q ? '0 : mem_rdata;
    assign rvalid = !empty_q;
  end else begin : g_std
    logic [DATASIZE-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_ok;
      if (rd_ok) rdata_d = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 4, address bits; DEPTH = 2**ADDRSIZE words.
REQ-003 SHALL have parameter AF_LEVEL, default 14, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports, one clock, asynchronous active-high reset:
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  asynchronous active-high reset
- wdata  in  DATASIZE  write data
- winc  in  1  write request
- rinc  in  1  read / pop request
- clr_err  in  1  clears sticky error flags
- rdata  out  DATASIZE  read data
- rvalid  out  1  rdata qualifier
- full  out  1  DEPTH words stored
- empty  out  1  zero words stored
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDRSIZE+1  words stored, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Function
REQ-007 SHALL use ADDRSIZE+1-bit write/read pointers; low ADDRSIZE bits address memory; pointers wrap naturally from 2*DEPTH-1 to 0.
REQ-008 SHALL accept a write iff winc && !full (full sampled before the edge); accepted write stores wdata at wptr and increments wptr.
REQ-009 SHALL accept a read iff rinc && !empty; accepted read increments rptr.
REQ-010 SHALL, with winc && rinc both accepted in one cycle, leave count unchanged.
REQ-011 SHALL reject a write when full even if a read is accepted in the same cycle; overflow sets.
REQ-012 SHALL reject a read when empty even if a write is accepted in the same cycle; underflow sets.
REQ-013 SHALL hold count, full, empty, almost_full, almost_empty as registers updated on the edge of the accepted operation (visible the cycle after).
REQ-014 SHALL, with FWFT=0, register mem[rptr] into rdata on an accepted read and pulse rvalid high for exactly the following cycle; rdata holds its value otherwise.
REQ-015 SHALL, with FWFT=1, drive rdata = mem[rptr low bits] continuously and rvalid = !empty; rinc pops the presented word.
REQ-016 SHALL set overflow/underflow on the offending edge; clr_err clears both; simultaneous set and clear: set wins.
REQ-017 SHALL NOT alter memory contents or pointers on rejected operations.

Reset
REQ-018 SHALL, on rst assertion, immediately force: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, rdata 0, rvalid 0, overflow 0, underflow 0.
REQ-019 SHALL NOT reset memory array contents; stored data is discarded logically by the pointer reset, including mid-operation.
REQ-020 SHALL ignore winc/rinc in the first edge during which rst is high.

Structure
REQ-021 SHALL place a shared package sync_fifo_pkg holding the mode enum (FIFO_STD, FIFO_FWFT) and default parameter constants.
REQ-022 SHALL instantiate one sub-module sync_fifo_mem: DEPTH x DATASIZE array, synchronous write, asynchronous read, no reset.
REQ-023 SHALL keep pointer, count, flag and error logic in sync_fifo itself.

Verification
REQ-024 Reset, then write 0x01..0x10 (16 words, DEPTH=16) -> full=1, count=16, almost_full=1 from 14th write onward, overflow=0.
REQ-025 From full, one more winc with wdata=0xAA -> overflow=1, count stays 16, later reads return 0x01..0x10 with no 0xAA.
REQ-026 FWFT=0: write 0x5A to empty, then rinc -> rdata=0x5A with rvalid=1 exactly one cycle after the rinc edge; empty=1 afterwards.
REQ-027 FWFT=1: write 0x3C to empty -> rdata=0x3C and rvalid=1 the cycle after the write, without rinc.
REQ-028 Count=8, winc && rinc for 20 cycles (pointers wrap) -> count stays 8, data order preserved; rinc on empty -> underflow=1, clr_err -> underflow=0.
REQ-029 Assert rst asynchronously mid-burst with count=5 -> all outputs at reset values before next clk edge; subsequent write/read of 0x77 returns 0x77.
